multi_cycle_control_unit: RTL
=============================

# multi_cycle_control_unit

FSM controller that sequences the shared multi-cycle RV32I datapath: one memory port, one ALU, PC/IR/MDR/ALUOut registers. It decodes the IR opcode and drives every datapath enable and mux select per state. It stalls on a memory-ready handshake and computes the final PC write enable from the ALU branch condition. The ALU control unit stays downstream and interprets `alu_op` together with funct3/funct7.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  7  IR[6:0]; decoded in ID/EX/MEM/WB, ignored in IF.
- `bcond`  in  1  ALU branch-condition result, combinational in the same cycle.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `halt_req`  in  1  ECALL halt condition (x17==10), sampled in EX.
- `pc_write`  out  1  PC load enable, already combined with `bcond`.
- `i_or_d`  out  1  memory address select: 0=PC, 1=ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`, `mdr_write`, `alu_out_write`  out  1 each  register load enables.
- `mem_to_reg`  out  1  rd data: 0=ALUOut, 1=MDR.
- `reg_write`  out  1  register-file write enable.
- `pc_source`  out  1  PC input: 0=ALU result, 1=ALUOut.
- `alu_src_a`  out  1  0=PC, 1=A register.
- `alu_src_b`  out  2  00=B register, 01=constant 4, 10=immediate.
- `alu_op`  out  2  00=add, 01=branch compare, 10=funct-decoded.
- `is_ecall`, `illegal_inst`, `retire`  out  1 each  single-cycle pulses.
- `is_halted`  out  1  sticky halt flag.
- `state`  out  3  debug state: IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, HALT=6.

## Operation
- Opcode classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011. Any other value is illegal.
- Outputs are Moore/Mealy combinational from `state`, `opcode`, `bcond` and `mem_ready`. Every output not listed for a state is 0.
- IF: `mem_read`=1, `i_or_d`=0, `ir_write`=`mem_ready`. Stay in IF until `mem_ready`, then go to ID.
- ID: `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `alu_out_write`=1, so ALUOut<=PC+4. Go to EX.
- EX, R/I: `alu_src_a`=1, `alu_src_b`=00 (R) or 10 (I), `alu_op`=10, `alu_out_write`=1, `pc_write`=1, `pc_source`=1. Go to WB.
- EX, LOAD/STORE: same PC update; `alu_src_b`=10, `alu_op`=00. Go to MEM.
- PC update in EX: PC samples the old ALUOut (PC+4) on the same edge that ALUOut is overwritten.
- EX, BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=1, `pc_write`=!`bcond`. If `bcond`=1 go to BR, else go to IF with `retire`=1.
- BR: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00, `pc_write`=1, `pc_source`=0, `retire`=1. Go to IF.
- EX, JAL: `alu_src_a`=0; JALR: `alu_src_a`=1. Both: `alu_src_b`=10, `alu_op`=00, `pc_write`=1, `pc_source`=0, `alu_out_write`=0 (ALUOut keeps PC+4 as link). Go to WB.
- EX, ECALL: `is_ecall`=1, `pc_write`=1, `pc_source`=1. If `halt_req`=1 go to HALT, else go to IF with `retire`=1.
- EX, illegal: `illegal_inst`=1, `pc_write`=1, `pc_source`=1 (instruction treated as NOP). Go to IF. No `retire`.
- MEM: `i_or_d`=1.
  - LOAD: `mem_read`=1, `mdr_write`=`mem_ready`; go to WB on `mem_ready`.
  - STORE: `mem_write`=1; on `mem_ready`, `retire`=1 and go to IF.
  - Hold MEM while `mem_ready`=0.
- WB: `reg_write`=1, `mem_to_reg`=1 for LOAD else 0, `retire`=1. Go to IF.
- HALT: terminal. `is_halted`=1, all enables 0. Leave HALT only by reset.

## Timing
- While `reset`=1, every output is 0, including `is_halted` and `state`. The clock edge with reset high loads IF.
- First cycle after reset release: IF with `mem_read`=1.
- Cycle counts with `mem_ready` held 1:
  - R/I/JAL/JALR: 4 (IF, ID, EX, WB).
  - LOAD: 5.
  - STORE: 4.
  - Branch not taken: 3.
  - Branch taken: 4.
  - ECALL: 3.
- Each cycle of `mem_ready`=0 in IF or MEM adds exactly one cycle. No enable other than the held strobes is asserted during a stall.
- `retire` pulses exactly once per completed legal instruction, in its final cycle.
- Reset mid-instruction, in any state: outputs 0 in that same cycle, IF on the next edge. No partial write completes.
- `mem_ready` outside IF/MEM is ignored. `bcond` is used only in EX for BRANCH.

## Test plan
- Reset held 2 cycles: all outputs 0. After release: `state`=0, `mem_read`=1, `i_or_d`=0, `ir_write`=0 until `mem_ready`=1.
- ADD (0110011), `mem_ready`=1: states 0,1,2,4. EX has `pc_write`=1, `pc_source`=1, `alu_op`=10. WB has `reg_write`=1, `mem_to_reg`=0, `retire`=1. Then IF.
- LW with `mem_ready` low for 3 MEM cycles: MEM lasts 4 cycles with `mem_read`=1 and `i_or_d`=1. `mdr_write`=1 only in the 4th. Next WB has `mem_to_reg`=1, for 8 cycles total.
- BEQ:
  - `bcond`=0: EX `pc_write`=1, `pc_source`=1, `retire`=1, back to IF, 3 cycles.
  - `bcond`=1: EX `pc_write`=0, then BR with `pc_write`=1, `pc_source`=0, `alu_src_b`=10.
- JALR: EX has `alu_out_write`=0, `pc_write`=1, `pc_source`=0, `alu_src_a`=1. WB has `reg_write`=1, `mem_to_reg`=0.
- ECALL sequence:
  - `halt_req`=0: `is_ecall` pulse, return to IF.
  - `halt_req`=1: `state`=6, `is_halted`=1 held for 20 cycles; reset clears it.
- Opcode 7'h7F: `illegal_inst`=1 in EX, no `retire`, PC advances, IF next.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// Control FSM for the shared multi-cycle RV32I datapath: sequences IF/ID/EX/MEM/WB/BR/HALT
// and drives every datapath enable and mux select from the current state and IR opcode.
module multi_cycle_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       alu_out_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_ecall,
    output logic       illegal_inst,
    output logic       retire,
    output logic       is_halted,
    output logic [2:0] state
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpEcall  = 7'b1110011;

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StEx   = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StBr   = 3'd5,
        StHalt = 3'd6
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    logic is_load;
    assign is_load = (opcode == OpLoad);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        alu_out_write = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        is_ecall      = 1'b0;
        illegal_inst  = 1'b0;
        retire        = 1'b0;
        is_halted     = 1'b0;

        unique case (state_q)
            StIf: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) state_d = StId;
            end
            StId: begin
                alu_src_b     = 2'b01;
                alu_out_write = 1'b1;
                state_d       = StEx;
            end
            StEx: begin
                // PC takes the old ALUOut (PC+4) while ALUOut is reloaded on the same edge
                case (opcode)
                    OpR, OpI: begin
                        alu_src_a     = 1'b1;
                        alu_src_b     = (opcode == OpI) ? 2'b10 : 2'b00;
                        alu_op        = 2'b10;
                        alu_out_write = 1'b1;
                        pc_write      = 1'b1;
                        pc_source     = 1'b1;
                        state_d       = StWb;
                    end
                    OpLoad, OpStore: begin
                        alu_src_a     = 1'b1;
                        alu_src_b     = 2'b10;
                        alu_out_write = 1'b1;
                        pc_write      = 1'b1;
                        pc_source     = 1'b1;
                        state_d       = StMem;
                    end
                    OpBranch: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_source = 1'b1;
                        pc_write  = !bcond;
                        retire    = !bcond;
                        state_d   = bcond ? StBr : StIf;
                    end
                    OpJal, OpJalr: begin
                        alu_src_a = (opcode == OpJalr);
                        alu_src_b = 2'b10;
                        pc_write  = 1'b1;
                        state_d   = StWb;
                    end
                    OpEcall: begin
                        is_ecall  = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        retire    = !halt_req;
                        state_d   = halt_req ? StHalt : StIf;
                    end
                    default: begin
                        illegal_inst = 1'b1;
                        pc_write     = 1'b1;
                        pc_source    = 1'b1;
                        state_d      = StIf;
                    end
                endcase
            end
            StMem: begin
                i_or_d = 1'b1;
                if (is_load) begin
                    mem_read  = 1'b1;
                    mdr_write = mem_ready;
                    if (mem_ready) state_d = StWb;
                end else begin
                    mem_write = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) state_d = StIf;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                retire     = 1'b1;
                state_d    = StIf;
            end
            StBr: begin
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = StIf;
            end
            StHalt: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = StIf;
            end
        endcase

        // Reset forces every output low in the same cycle so no partial write completes
        if (reset) begin
            pc_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mdr_write     = 1'b0;
            alu_out_write = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            pc_source     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            is_ecall      = 1'b0;
            illegal_inst  = 1'b0;
            retire        = 1'b0;
            is_halted     = 1'b0;
        end
    end

    assign state = reset ? 3'd0 : state_q;

endmodule
